// File: rtl/vga_scanout.sv
// vga_scanout: scans a 320x240 3-bit framebuffer and drives pixel-doubled 640x480@60 VGA.
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clock,
   input  logic        reset,
   output logic [18:0] ram_address,
   input  logic [2:0]  ram_read_data,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_start
);
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_LO = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
   localparam int V_SYNC_LO = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;
   logic       pix_en;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       visible;
   logic       h_last;
   logic       v_last;
   always_comb begin
      visible     = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
      h_last      = h_cnt == 10'(H_TOTAL - 1);
      v_last      = v_cnt == 10'(V_TOTAL - 1);
      ram_address = visible ? 19'(H_VISIBLE / 2) * 19'(v_cnt[9:1]) + 19'(h_cnt[9:1]) : '0;
   end
   // Outputs sample RAM data one clock after the address, so they trail the counters by one slot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_en      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else begin
         pix_en      <= ~pix_en;
         frame_start <= pix_en && h_cnt == '0 && v_cnt == '0;
         if (pix_en) begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last)
               v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            hsync <= !(h_cnt >= 10'(H_SYNC_LO) && h_cnt < 10'(H_SYNC_HI));
            vsync <= !(v_cnt >= 10'(V_SYNC_LO) && v_cnt < 10'(V_SYNC_HI));
            red   <= visible ? {4{ram_read_data[2]}} : 4'h0;
            green <= visible ? {4{ram_read_data[1]}} : 4'h0;
            blue  <= visible ? {4{ram_read_data[0]}} : 4'h0;
         end
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks a reduced-geometry and a full-geometry scanout against a clock-count model.
module tb_vga_scanout;
   typedef struct packed {
      logic [18:0] addr;
      logic        hs;
      logic        vs;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        fs;
   } obs_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [18:0] s_addr, f_addr;
   logic [2:0]  s_rd, f_rd;
   logic        s_hs, s_vs, s_fs, f_hs, f_vs, f_fs;
   logic [3:0]  s_r, s_g, s_b, f_r, f_g, f_b;
   logic [2:0]  mem [32];
   int          e = 0;
   int          errors = 0;
   int          checks = 0;
   int          fs_n, fs1, fs2;

   always #10 clock = ~clock;

   vga_scanout #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
                 .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut (
      .clock(clock), .reset(reset), .ram_address(s_addr), .ram_read_data(s_rd),
      .hsync(s_hs), .vsync(s_vs), .red(s_r), .green(s_g), .blue(s_b), .frame_start(s_fs));

   vga_scanout dut_full (
      .clock(clock), .reset(reset), .ram_address(f_addr), .ram_read_data(f_rd),
      .hsync(f_hs), .vsync(f_vs), .red(f_r), .green(f_g), .blue(f_b), .frame_start(f_fs));

   // Registered-read RAMs with one clock of latency
   always @(posedge clock) begin
      s_rd <= mem[s_addr[4:0]];
      f_rd <= f_addr[2:0] ^ f_addr[8:6];
   end

   // Clocks elapsed since reset release
   always @(posedge clock or posedge reset)
      if (reset) e <= 0;
      else e <= e + 1;

   function automatic int addr_of(int p, int hv, int vv, int ht);
      int h = p % ht;
      int v = p / ht;
      return (h < hv && v < vv) ? (hv / 2) * (v / 2) + h / 2 : 0;
   endfunction

   function automatic obs_t model(int clk, bit full);
      int hv = full ? 640 : 16, hf = full ? 16 : 2, hw = full ? 96 : 4, hb = full ? 48 : 2;
      int vv = full ? 480 : 8,  vf = full ? 10 : 1, vw = full ? 2 : 2,  vb = full ? 33 : 1;
      int ht = hv + hf + hw + hb;
      int vt = vv + vf + vw + vb;
      int a = clk / 2;
      int q, h, v, qa;
      logic [2:0] d;
      obs_t o;
      o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.addr = 19'(addr_of(a % (ht * vt), hv, vv, ht));
      if (a > 0) begin
         q = (a - 1) % (ht * vt);
         h = q % ht;
         v = q / ht;
         o.hs = !(h >= hv + hf && h < hv + hf + hw);
         o.vs = !(v >= vv + vf && v < vv + vf + vw);
         if (h < hv && v < vv) begin
            qa = addr_of(q, hv, vv, ht);
            d = full ? 3'(qa) ^ 3'(qa >> 6) : mem[qa];
            o.r = {4{d[2]}};
            o.g = {4{d[1]}};
            o.b = {4{d[0]}};
         end
         o.fs = (clk % 2 == 0) && q == 0;
      end
      return o;
   endfunction

   task automatic chk(string tag, logic [33:0] got, logic [33:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s at clk %0d: got %h required %h", tag, e, got, exp);
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk("small", {s_addr, s_hs, s_vs, s_r, s_g, s_b, s_fs}, model(e, 1'b0));
         chk("full", {f_addr, f_hs, f_vs, f_r, f_g, f_b, f_fs}, model(e, 1'b1));
         if (s_fs && !reset) begin
            if (fs_n == 0) fs1 = e;
            else if (fs_n == 1) fs2 = e;
            fs_n++;
         end
      end
   endtask

   task automatic restart();
      @(negedge clock);
      reset = 1'b1;
      run(3);
      reset = 1'b0;
      fs_n = 0;
      fs1 = -1;
      fs2 = -1;
   endtask

   initial begin
      int found;
      logic [11:0] pal_exp [4];
      #5 reset = 1'b1;
      foreach (mem[i]) mem[i] = 3'($urandom);
      run(4);
      chk("reset_state", {s_addr, s_hs, s_vs, s_r, s_g, s_b, s_fs}, {19'd0, 1'b1, 1'b1, 12'd0, 1'b0});
      reset = 1'b0;
      fs_n = 0;
      fs1 = -1;
      fs2 = -1;
      run(3300);
      chk("fs_first", 34'(fs1), 34'd2);
      chk("fs_period", 34'(fs2 - fs1), 34'd576);

      foreach (mem[i]) mem[i] = 3'b000;
      mem[5] = 3'b110;
      mem[6] = 3'b111;
      mem[7] = 3'b011;
      restart();
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         found = (s_addr == 19'd5) ? 1 : 0;
      end
      chk("addr5_seen", 34'(found), 34'd1);
      repeat (2) @(negedge clock);
      pal_exp = '{12'hFF0, 12'hFF0, 12'hFF0, 12'hFF0};
      for (int i = 0; i < 4; i++) begin
         chk("palette_110", 34'({s_r, s_g, s_b}), 34'(pal_exp[i]));
         @(negedge clock);
      end
      chk("palette_111", 34'({s_r, s_g, s_b}), 34'h0FFF);
      run(700);

      foreach (mem[i]) mem[i] = 3'b111;
      restart();
      run(700);

      foreach (mem[i]) mem[i] = 3'($urandom);
      restart();
      run(300 + $urandom_range(0, 40));
      #2 reset = 1'b1;
      #1 chk("mid_reset", {s_addr, s_hs, s_vs, s_r, s_g, s_b, s_fs}, {19'd0, 1'b1, 1'b1, 12'd0, 1'b0});
      run(3);
      reset = 1'b0;
      fs_n = 0;
      fs1 = -1;
      fs2 = -1;
      run(700);
      chk("fs_after_mid", 34'(fs1), 34'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
